// File: rtl/tick_seg_counter.sv
// Counts edges of an asynchronous blink toggle modulo MODULUS and drives a registered
// seven-segment display. Define TICK_BOTH_EDGES_EN to count both tick transitions.
module tick_seg_counter #(
   parameter int unsigned MODULUS      = 10,
   parameter int unsigned COMMON_ANODE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_in,
   input  logic       enable,
   input  logic       clear,
   output logic [3:0] count,
   output logic       wrap,
   output logic       seg_a,
   output logic       seg_b,
   output logic       seg_c,
   output logic       seg_d,
   output logic       seg_e,
   output logic       seg_f,
   output logic       seg_g
);

   if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
      $error("tick_seg_counter: MODULUS must be in 2..16");
   end

   localparam logic [3:0] LastCount = 4'(MODULUS - 1);
   localparam logic [6:0] SegOff    = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {StBlank, StRun, StPaused} state_e;

   state_e     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic       wrap_q, wrap_d;
   logic [6:0] seg_q, seg_nxt;
   logic       s1_q, s2_q, p_q;
   logic       tick_edge;

   // Active-high a..g in bits 6..0.
   function automatic logic [6:0] seg_decode(input logic [3:0] value);
      logic [6:0] pat;
      pat = 7'b0000000;
      case (value)
         4'h0:    pat = 7'b1111110;
         4'h1:    pat = 7'b0110000;
         4'h2:    pat = 7'b1101101;
         4'h3:    pat = 7'b1111001;
         4'h4:    pat = 7'b0110011;
         4'h5:    pat = 7'b1011011;
         4'h6:    pat = 7'b1011111;
         4'h7:    pat = 7'b1110000;
         4'h8:    pat = 7'b1111111;
         4'h9:    pat = 7'b1111011;
         4'hA:    pat = 7'b1110111;
         4'hB:    pat = 7'b0011111;
         4'hC:    pat = 7'b1001110;
         4'hD:    pat = 7'b0111101;
         4'hE:    pat = 7'b1001111;
         default: pat = 7'b1000111;
      endcase
      return pat;
   endfunction

`ifdef TICK_BOTH_EDGES_EN
   assign tick_edge = s2_q ^ p_q;
`else
   assign tick_edge = s2_q & ~p_q;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear) begin
         // A coincident edge is dropped on purpose.
         state_d = StBlank;
         count_d = 4'd0;
      end else begin
         unique case (state_q)
            StBlank: begin
               count_d = 4'd0;
               if (tick_edge && enable) begin
                  count_d = 4'd1;
                  state_d = StRun;
               end
            end
            StRun: begin
               if (!enable) begin
                  state_d = StPaused;
               end else if (tick_edge) begin
                  if (count_q == LastCount) begin
                     count_d = 4'd0;
                     wrap_d  = 1'b1;
                  end else begin
                     count_d = count_q + 4'd1;
                  end
               end
            end
            StPaused: begin
               if (enable) state_d = StRun;
            end
            default: begin
               state_d = StBlank;
               count_d = 4'd0;
            end
         endcase
      end
   end

   // Display follows the registered count, so it trails count by one cycle.
   always_comb begin
      seg_nxt = SegOff;
      if (state_q != StBlank) begin
         seg_nxt = (COMMON_ANODE != 0) ? ~seg_decode(count_q) : seg_decode(count_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         p_q     <= 1'b0;
         state_q <= StBlank;
         count_q <= 4'd0;
         wrap_q  <= 1'b0;
         seg_q   <= SegOff;
      end else begin
         s1_q    <= tick_in;
         s2_q    <= s1_q;
         p_q     <= s2_q;
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         seg_q   <= seg_nxt;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign seg_a = seg_q[6];
   assign seg_b = seg_q[5];
   assign seg_c = seg_q[4];
   assign seg_d = seg_q[3];
   assign seg_e = seg_q[2];
   assign seg_f = seg_q[1];
   assign seg_g = seg_q[0];

endmodule

// File: tb/tb_tick_seg_counter.sv
// Bench for tick_seg_counter: event-queue model checked every cycle plus directed literal checks.
// The TICK_BOTH_EDGES_EN build runs the both-edges wrap scenario instead of the default set.
module tb_tick_seg_counter;

`ifdef TICK_BOTH_EDGES_EN
   localparam int unsigned Mod = 16;
`else
   localparam int unsigned Mod = 10;
`endif
   localparam int unsigned Ca = 1;
   localparam logic [6:0] SegOff = 7'h7F;
   localparam logic [6:0] HexPat [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_in = 1'b0;
   logic       enable = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] count;
   logic       wrap;
   logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
   logic [6:0] segs;

   int tests = 0;
   int fails = 0;
   int wrap_cnt = 0;
   bit saw_f = 1'b0;

   // Model state: 0 blank, 1 run, 2 paused.
   int         mstate = 0;
   int         mcount = 0;
   logic       mwrap = 1'b0;
   logic [6:0] mseg = SegOff;
   bit         model_valid = 1'b0;
   int         cyc = 0;
   int         due[$];
   logic       last_tk = 1'b0;

   assign segs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   always #5 clk = ~clk;

   tick_seg_counter #(.MODULUS(Mod), .COMMON_ANODE(Ca)) dut (
      .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .enable(enable), .clear(clear),
      .count(count), .wrap(wrap),
      .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
      .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] display(input int st, input int c);
      logic [6:0] p;
      if (st == 0) return SegOff;
      p = HexPat[c];
      return (Ca != 0) ? ~p : p;
   endfunction

   // Model: a tick change sampled at clock n becomes a counting event at clock n+2.
   initial begin
      logic tk;
      logic trig;
      bit   ev;
      forever begin
         @(posedge clk);
         cyc++;
         tk = tick_in;
         if (!rst_n) begin
            mstate = 0;
            mcount = 0;
            mwrap = 1'b0;
            mseg = SegOff;
            due.delete();
            last_tk = 1'b0;
            model_valid = 1'b1;
         end else begin
            ev = (due.size() > 0) && (due[0] == cyc);
            if (ev) void'(due.pop_front());
            mseg = display(mstate, mcount);
            mwrap = 1'b0;
            if (clear) begin
               mstate = 0;
               mcount = 0;
            end else if (mstate == 0) begin
               if (ev && enable) begin
                  mcount = 1;
                  mstate = 1;
               end
            end else if (mstate == 1) begin
               if (!enable) mstate = 2;
               else if (ev) begin
                  if (mcount == int'(Mod) - 1) begin
                     mcount = 0;
                     mwrap = 1'b1;
                  end else mcount = mcount + 1;
               end
            end else if (enable) mstate = 1;
`ifdef TICK_BOTH_EDGES_EN
            trig = tk ^ last_tk;
`else
            trig = tk & ~last_tk;
`endif
            if (trig) due.push_back(cyc + 2);
            last_tk = tk;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            check("count", 32'(count), 32'(mcount));
            check("wrap", 32'(wrap), 32'(mwrap));
            check("segs", 32'(segs), 32'(mseg));
            if (wrap) wrap_cnt++;
            if (segs == 7'b0111000) saw_f = 1'b1;
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      tick_in = 1'b1;
      clks(h);
      tick_in = 1'b0;
      clks(l);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      clks(1);
      clear = 1'b0;
      clks(1);
   endtask

   initial begin
      clks(3);
      rst_n = 1'b1;
      check("reset_count", 32'(count), 32'd0);
      check("blank_before_edge", 32'(segs), 32'h7F);
`ifndef TICK_BOTH_EDGES_EN
      // Three edges spaced 20 clocks, exact latency on the third.
      pulse(10, 10);
      pulse(10, 10);
      tick_in = 1'b1;
      clks(1);
      check("lat_k1_count", 32'(count), 32'd2);
      clks(1);
      check("lat_k2_count", 32'(count), 32'd2);
      clks(1);
      check("lat_count3", 32'(count), 32'd3);
      check("lat_seg_still2", 32'(segs), 32'b0010010);
      clks(1);
      check("lat_seg3", 32'(segs), 32'b0000110);
      clks(6);
      tick_in = 1'b0;
      clks(10);

      // Full wrap of a decade.
      do_clear();
      wrap_cnt = 0;
      for (int i = 0; i < 10; i++) pulse(3, 3);
      clks(4);
      check("wrap_pulses", 32'(wrap_cnt), 32'd1);
      check("wrap_count0", 32'(count), 32'd0);
      check("wrap_seg0", 32'(segs), 32'b0000001);

      // Pause discards edges.
      do_clear();
      for (int i = 0; i < 4; i++) pulse(3, 3);
      check("pause_pre", 32'(count), 32'd4);
      enable = 1'b0;
      clks(2);
      for (int i = 0; i < 5; i++) begin
         pulse(3, 3);
         check("pause_hold", 32'(count), 32'd4);
      end
      enable = 1'b1;
      clks(2);
      pulse(3, 3);
      clks(2);
      check("pause_resume", 32'(count), 32'd5);

      // Clear coincident with a valid edge at count 7.
      do_clear();
      for (int i = 0; i < 7; i++) pulse(3, 3);
      check("clr_pre", 32'(count), 32'd7);
      tick_in = 1'b1;
      clks(2);
      clear = 1'b1;
      clks(1);
      clear = 1'b0;
      check("clr_count", 32'(count), 32'd0);
      check("clr_nowrap", 32'(wrap), 32'd0);
      clks(1);
      check("clr_blank", 32'(segs), 32'h7F);
      tick_in = 1'b0;
      clks(5);
      check("clr_edge_lost", 32'(count), 32'd0);

      // Reset with an edge in flight at count 6.
      for (int i = 0; i < 6; i++) pulse(3, 3);
      check("rst_pre", 32'(count), 32'd6);
      tick_in = 1'b1;
      clks(1);
      rst_n = 1'b0;
      clks(1);
      rst_n = 1'b1;
      tick_in = 1'b0;
      check("rst_count", 32'(count), 32'd0);
      check("rst_blank", 32'(segs), 32'h7F);
      clks(6);
      check("rst_edge_lost", 32'(count), 32'd0);
      check("rst_still_blank", 32'(segs), 32'h7F);
`else
      wrap_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         tick_in = ~tick_in;
         clks(4);
      end
      clks(4);
      check("both_wraps", 32'(wrap_cnt), 32'd2);
      check("both_saw_f", 32'(saw_f), 32'd1);
      check("both_count0", 32'(count), 32'd0);
      check("both_seg0", 32'(segs), 32'b0000001);
`endif
      clks(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
